cci_mpf_shim_vtp_svc_reorder: RTL and testbench
===============================================

# cci_mpf_shim_vtp_svc_reorder

Client-side front end of the VTP translation service. It accepts in-order 4KB page translation requests from a VTP pipeline shim and allocates a unique tag for each. It forwards them over the service client port and collects the out-of-order service responses in a tag-indexed buffer. Translations are returned to the pipeline strictly in request order.

## Interface
- N_ENTRIES, 16, reorder slots. Power of 2, at most CCI_MPF_SHIM_VTP_MAX_SVC_REQS. Tag = slot index, zero-extended to t_cci_mpf_shim_vtp_req_tag.
- clk  in  1  clock. Everything is sampled on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- reqEn  in  1  pipeline request valid. Legal only when reqRdy=1.
- reqPageVA  in  t_tlb_4kb_va_page_idx  4KB-aligned VA page to translate.
- reqRdy  out  1  slot available and the service is ready.
- svc.lookupEn  out  1  service request enable (cci_mpf_shim_vtp_svc_if.client).
- svc.lookupReq  out  t_cci_mpf_shim_vtp_lookup_req  {pageVA, tag}.
- svc.lookupRdy  in  1  service can accept a request.
- svc.lookupRspValid  in  1  service response valid.
- svc.lookupRsp  in  t_cci_mpf_shim_vtp_lookup_rsp  {pagePA, tag, isBigPage}.
- rspValid  out  1  head-of-order translation available.
- rspPagePA  out  t_tlb_4kb_pa_page_idx  translated page of the head entry.
- rspIsBigPage  out  1  head entry is a 2MB page.
- rspDeq  in  1  consumer takes the head. Legal only when rspValid=1.
- numOutstanding  out  $clog2(N_ENTRIES)+1  allocated slots (requested, not yet dequeued).
- errTag  out  1  sticky error: a response arrived for an unallocated slot, or for a slot already filled.

## Operation
- State:
  - wrPtr and rdPtr: $clog2(N_ENTRIES) bits each, wrapping modulo N_ENTRIES.
  - count: 0..N_ENTRIES.
  - Per slot: alloc bit, filled bit, pagePA, isBigPage.
- Allocation:
  - reqRdy = (count != N_ENTRIES) && svc.lookupRdy.
  - svc.lookupEn = reqEn && reqRdy (combinational pass-through).
  - svc.lookupReq.pageVA = reqPageVA; svc.lookupReq.tag = wrPtr.
  - On svc.lookupEn: set alloc[wrPtr], clear filled[wrPtr], advance wrPtr.
- Fill:
  - On svc.lookupRspValid with tag t, if alloc[t] && !filled[t]: write pagePA and isBigPage to slot t and set filled[t].
  - Otherwise: set errTag and leave the slot unchanged.
- Drain:
  - rspValid = filled[rdPtr]; rspPagePA and rspIsBigPage read slot rdPtr.
  - On rspDeq: clear alloc[rdPtr] and filled[rdPtr], advance rdPtr.
- count update: +1 on allocate only, -1 on dequeue only, unchanged when both occur in the same cycle. numOutstanding = count.
- Simultaneous events:
  - Allocate of slot wrPtr and dequeue of slot rdPtr in one cycle: both take effect (the slots are distinct unless count is 0 or N_ENTRIES).
  - A fill to the slot at rdPtr in the same cycle as a dequeue cannot occur, because a dequeue requires filled=1.
- Full: at count=N_ENTRIES, reqRdy=0 regardless of svc.lookupRdy.
  - A dequeue in that cycle does not raise reqRdy until the next cycle; reqRdy depends on registered count only.
- Empty: at count=0, rspValid=0.
- Reset (asynchronous, any time, including mid-operation):
  - wrPtr, rdPtr and count go to 0; all alloc and filled bits clear; errTag goes to 0.
  - Outstanding service responses arriving after reset are flagged as errTag. Upstream must reset the service together with this block.
- Reset values of outputs: reqRdy=0 while reset_n=0, then it follows svc.lookupRdy; svc.lookupEn=0; rspValid=0; numOutstanding=0; errTag=0. svc.lookupReq and rspPagePA are don't-care while their valids are 0.

## Timing
- Request path: zero cycles. reqEn to svc.lookupEn in the same cycle.
- Response path: one cycle. A response at edge t raises rspValid in cycle t+1 if its slot is the head.
  - Non-head responses wait until all older slots are dequeued.
- Dequeue: the next head becomes visible the cycle after rspDeq, if that slot is filled.
- Throughput: one allocate, one fill and one dequeue per cycle, sustained.
- pagePA storage is a register array (or MLAB) with a registered write; the read address is rdPtr.

## Test plan
- In-order single request, reqPageVA=0x123: tag=0 on the lookup port; response {pagePA=0x456, tag 0, big=0} at t; rspValid=1 at t+1 with rspPagePA=0x456; numOutstanding goes 1→0 after rspDeq.
- Out-of-order: issue 4 requests (tags 0..3); respond in order 3,1,2,0 with PA=0x10+tag. rspValid stays 0 until tag 0 arrives, then outputs 0x10, 0x11, 0x12, 0x13 on consecutive cycles with rspDeq held high.
- Full: issue 16 requests with no responses. reqRdy=0 at numOutstanding=16; fill and dequeue tag 0; reqRdy=1 the following cycle and the next tag issued is 0 (wrap).
- Back-pressure: svc.lookupRdy=0 with reqEn=1: svc.lookupEn=0, reqRdy=0, no allocation. Simultaneous allocate and dequeue at count=5 keeps count at 5.
- Errors: a response with tag 7 when only tags 0..2 are allocated sets errTag, which stays high. A second response to an already-filled tag 1 also sets errTag and leaves the stored PA unchanged.
- Reset mid-operation: assert reset_n=0 with 6 outstanding. rspValid, numOutstanding and errTag go to 0 immediately; after release, the first tag issued is 0.

Source files
------------

// File: rtl/cci_mpf_shim_vtp_svc_reorder.sv
// cci_mpf_shim_vtp_svc_reorder
//
// Client-side front end of the VTP translation service. In-order page
// translation requests from a pipeline shim each get a unique tag. The tag is
// the reorder slot index. Requests go to the service client port. Responses
// from the service may arrive out of order; they are parked in a tag-indexed
// buffer. Translations are handed back to the pipeline strictly in request
// order.
//
// Ports
//   clk, reset_n              clock, asynchronous active-low reset
//   reqEn, reqPageVA, reqRdy  pipeline request (reqEn legal only with reqRdy)
//   svc_lookupEn              service request enable (same cycle as reqEn)
//   svc_lookupReqPageVA/Tag   service request payload {pageVA, tag}
//   svc_lookupRdy             service can accept a request
//   svc_lookupRspValid        service response valid
//   svc_lookupRspPagePA/Tag/IsBigPage  service response payload
//   rspValid, rspPagePA, rspIsBigPage  head-of-order translation
//   rspDeq                    consumer takes the head (legal only with rspValid)
//   numOutstanding            allocated slots (requested, not yet dequeued)
//   errTag                    sticky: response to an unallocated or already-filled slot
//
// N_ENTRIES must be a power of two, at least 2, and no larger than 2**TAG_BITS.
module cci_mpf_shim_vtp_svc_reorder #(
  parameter int N_ENTRIES = 16,
  parameter int TAG_BITS  = 5,
  parameter int VA_BITS   = 36,
  parameter int PA_BITS   = 36
) (
  input  logic                        clk,
  input  logic                        reset_n,

  input  logic                        reqEn,
  input  logic [VA_BITS-1:0]          reqPageVA,
  output logic                        reqRdy,

  output logic                        svc_lookupEn,
  output logic [VA_BITS-1:0]          svc_lookupReqPageVA,
  output logic [TAG_BITS-1:0]         svc_lookupReqTag,
  input  logic                        svc_lookupRdy,
  input  logic                        svc_lookupRspValid,
  input  logic [PA_BITS-1:0]          svc_lookupRspPagePA,
  input  logic [TAG_BITS-1:0]         svc_lookupRspTag,
  input  logic                        svc_lookupRspIsBigPage,

  output logic                        rspValid,
  output logic [PA_BITS-1:0]          rspPagePA,
  output logic                        rspIsBigPage,
  input  logic                        rspDeq,

  output logic [$clog2(N_ENTRIES):0]  numOutstanding,
  output logic                        errTag
);

  localparam int IDX_W = $clog2(N_ENTRIES);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(N_ENTRIES);

  logic [IDX_W-1:0]     wr_ptr;
  logic [IDX_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [N_ENTRIES-1:0] alloc;
  logic [N_ENTRIES-1:0] filled;
  logic [N_ENTRIES-1:0] alloc_nxt;
  logic [N_ENTRIES-1:0] filled_nxt;
  logic                 err;

  // Translation storage: written only by a legal fill, read at the head.
  logic [PA_BITS-1:0]   pa_mem [N_ENTRIES];
  logic [N_ENTRIES-1:0] big_mem;

  logic [IDX_W-1:0]     rsp_idx;
  logic                 rsp_in_range;
  logic                 fill_ok;
  logic                 fill_err;
  logic                 alloc_en;
  logic                 deq_en;

  // Handshakes, fill legality and head-of-order read.
  always_comb begin
    // reqRdy looks only at registered count, so a dequeue never frees a
    // slot for an allocate in the same cycle.
    reqRdy              = reset_n && (count != FULL_COUNT) && svc_lookupRdy;
    alloc_en            = reqEn && reqRdy;
    svc_lookupEn        = alloc_en;
    svc_lookupReqPageVA = reqPageVA;
    svc_lookupReqTag    = TAG_BITS'(wr_ptr);

    // Tags beyond the slot range can never have been issued.
    rsp_idx      = svc_lookupRspTag[IDX_W-1:0];
    rsp_in_range = ((svc_lookupRspTag >> IDX_W) == '0);
    fill_ok      = svc_lookupRspValid && rsp_in_range &&
                   alloc[rsp_idx] && !filled[rsp_idx];
    fill_err     = svc_lookupRspValid && !fill_ok;

    rspValid     = filled[rd_ptr];
    rspPagePA    = pa_mem[rd_ptr];
    rspIsBigPage = big_mem[rd_ptr];
    deq_en       = rspDeq && filled[rd_ptr];

    numOutstanding = count;
    errTag         = err;
  end

  // Next-state of the per-slot alloc/filled flags. The allocated slot is
  // always free (count < N_ENTRIES), and the dequeued slot is filled, so an
  // allocate, a fill and a dequeue never target the same slot legally.
  always_comb begin
    alloc_nxt  = alloc;
    filled_nxt = filled;
    for (int i = 0; i < N_ENTRIES; i++) begin
      alloc_nxt[i]  = (alloc_en && (wr_ptr == IDX_W'(i))) ? 1'b1 :
                      ((deq_en && (rd_ptr == IDX_W'(i))) ? 1'b0 : alloc[i]);
      filled_nxt[i] = ((alloc_en && (wr_ptr == IDX_W'(i))) ||
                       (deq_en && (rd_ptr == IDX_W'(i)))) ? 1'b0 :
                      ((fill_ok && (rsp_idx == IDX_W'(i))) ? 1'b1 : filled[i]);
    end
  end

  // Control state: pointers, occupancy, slot flags and sticky error.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      alloc  <= '0;
      filled <= '0;
      err    <= 1'b0;
    end else begin
      alloc  <= alloc_nxt;
      filled <= filled_nxt;
      if (alloc_en) wr_ptr <= wr_ptr + 1'b1;
      if (deq_en)   rd_ptr <= rd_ptr + 1'b1;
      if (fill_err) err    <= 1'b1;
      case ({alloc_en, deq_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Translation payload write; contents are meaningless until filled is set.
  always_ff @(posedge clk) begin
    if (fill_ok) begin
      pa_mem[rsp_idx]  <= svc_lookupRspPagePA;
      big_mem[rsp_idx] <= svc_lookupRspIsBigPage;
    end
  end

endmodule

// File: tb/tb_cci_mpf_shim_vtp_svc_reorder.sv
// Self-checking bench for cci_mpf_shim_vtp_svc_reorder. The bench plays the
// translation service: expected {isBigPage, pagePA} values are queued in
// request order and popped as the DUT presents each head translation.
module tb_cci_mpf_shim_vtp_svc_reorder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        reqEn;
  logic [35:0] reqPageVA;
  logic        reqRdy;
  logic        svc_lookupEn;
  logic [35:0] svc_lookupReqPageVA;
  logic [4:0]  svc_lookupReqTag;
  logic        svc_lookupRdy;
  logic        svc_lookupRspValid;
  logic [35:0] svc_lookupRspPagePA;
  logic [4:0]  svc_lookupRspTag;
  logic        svc_lookupRspIsBigPage;
  logic        rspValid;
  logic [35:0] rspPagePA;
  logic        rspIsBigPage;
  logic        rspDeq;
  logic [4:0]  numOutstanding;
  logic        errTag;

  int checks = 0;
  int errors = 0;
  logic [36:0] exp_q[$];
  logic [36:0] exp_v;

  always #5 clk = ~clk;

  cci_mpf_shim_vtp_svc_reorder dut (
    .clk                    (clk),
    .reset_n                (reset_n),
    .reqEn                  (reqEn),
    .reqPageVA              (reqPageVA),
    .reqRdy                 (reqRdy),
    .svc_lookupEn           (svc_lookupEn),
    .svc_lookupReqPageVA    (svc_lookupReqPageVA),
    .svc_lookupReqTag       (svc_lookupReqTag),
    .svc_lookupRdy          (svc_lookupRdy),
    .svc_lookupRspValid     (svc_lookupRspValid),
    .svc_lookupRspPagePA    (svc_lookupRspPagePA),
    .svc_lookupRspTag       (svc_lookupRspTag),
    .svc_lookupRspIsBigPage (svc_lookupRspIsBigPage),
    .rspValid               (rspValid),
    .rspPagePA              (rspPagePA),
    .rspIsBigPage           (rspIsBigPage),
    .rspDeq                 (rspDeq),
    .numOutstanding         (numOutstanding),
    .errTag                 (errTag)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reqEn = 1'b0; reqPageVA = '0; svc_lookupRdy = 1'b1;
    svc_lookupRspValid = 1'b0; svc_lookupRspPagePA = '0;
    svc_lookupRspTag = '0; svc_lookupRspIsBigPage = 1'b0; rspDeq = 1'b0;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    exp_q.delete();
  endtask

  // Service model: one response captured at the next edge.
  task automatic send_rsp(input logic [4:0] tag, input logic [35:0] pa, input logic big);
    svc_lookupRspValid = 1'b1;
    svc_lookupRspTag = tag;
    svc_lookupRspPagePA = pa;
    svc_lookupRspIsBigPage = big;
    tick();
    svc_lookupRspValid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; reqEn = 1'b1; reqPageVA = 36'h1; svc_lookupRdy = 1'b1;
    svc_lookupRspValid = 1'b0; svc_lookupRspPagePA = '0;
    svc_lookupRspTag = '0; svc_lookupRspIsBigPage = 1'b0; rspDeq = 1'b0;
    #2;
    checks++;
    if ({reqRdy, svc_lookupEn, rspValid, numOutstanding, errTag} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b en=%b valid=%b num=%0d err=%b expected all 0",
               reqRdy, svc_lookupEn, rspValid, numOutstanding, errTag);
    end
    tick();
    reqEn = 1'b0;
    reset_n = 1'b1;
    #1;
    checks++;
    if (reqRdy !== 1'b1 || numOutstanding !== 5'd0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b num=%0d expected rdy=1 num=0", reqRdy, numOutstanding);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    reqEn = 1'b1; reqPageVA = 36'h123;
    #1;
    checks++;
    if ({svc_lookupEn, svc_lookupReqTag, svc_lookupReqPageVA} !== {1'b1, 5'd0, 36'h123}) begin
      errors++;
      $display("FAIL single_lookup: got en=%b tag=%0d va=%0h expected en=1 tag=0 va=123",
               svc_lookupEn, svc_lookupReqTag, svc_lookupReqPageVA);
    end
    exp_q.push_back({1'b0, 36'h456});
    tick();
    reqEn = 1'b0;
    checks++;
    if (numOutstanding !== 5'd1 || rspValid !== 1'b0) begin
      errors++;
      $display("FAIL single_alloc: got num=%0d valid=%b expected num=1 valid=0", numOutstanding, rspValid);
    end
    send_rsp(5'd0, 36'h456, 1'b0);
    exp_v = exp_q.pop_front();
    checks++;
    if ({rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v}) begin
      errors++;
      $display("FAIL single_rsp: got valid=%b pa=%0h expected valid=1 pa=%0h", rspValid, rspPagePA, exp_v[35:0]);
    end
    rspDeq = 1'b1;
    tick();
    rspDeq = 1'b0;
    checks++;
    if (numOutstanding !== 5'd0 || rspValid !== 1'b0) begin
      errors++;
      $display("FAIL single_deq: got num=%0d valid=%b expected num=0 valid=0", numOutstanding, rspValid);
    end
  endtask

  task automatic test_out_of_order();
    logic [4:0] order [4];
    order[0] = 5'd3; order[1] = 5'd1; order[2] = 5'd2; order[3] = 5'd0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      reqEn = 1'b1; reqPageVA = 36'h200 + 36'(i);
      #1;
      checks++;
      if (svc_lookupEn !== 1'b1 || svc_lookupReqTag !== 5'(i)) begin
        errors++;
        $display("FAIL ooo_tag: got en=%b tag=%0d expected en=1 tag=%0d", svc_lookupEn, svc_lookupReqTag, i);
      end
      exp_q.push_back({(i == 2), 36'h10 + 36'(i)});
      tick();
    end
    reqEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send_rsp(order[k], 36'h10 + 36'(order[k]), (order[k] == 5'd2));
      if (k < 3) begin
        checks++;
        if (rspValid !== 1'b0) begin
          errors++;
          $display("FAIL ooo_wait: got valid=%b expected 0 after tag %0d", rspValid, order[k]);
        end
      end
    end
    rspDeq = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h0;
      checks++;
      if ({rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v}) begin
        errors++;
        $display("FAIL ooo_drain: got valid=%b big=%b pa=%0h expected valid=1 big=%b pa=%0h",
                 rspValid, rspIsBigPage, rspPagePA, exp_v[36], exp_v[35:0]);
      end
      tick();
    end
    rspDeq = 1'b0;
    checks++;
    if (numOutstanding !== 5'd0 || rspValid !== 1'b0) begin
      errors++;
      $display("FAIL ooo_empty: got num=%0d valid=%b expected num=0 valid=0", numOutstanding, rspValid);
    end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      reqEn = 1'b1; reqPageVA = 36'h300 + 36'(i);
      #1;
      checks++;
      if (svc_lookupEn !== 1'b1 || svc_lookupReqTag !== 5'(i)) begin
        errors++;
        $display("FAIL full_tag: got en=%b tag=%0d expected en=1 tag=%0d", svc_lookupEn, svc_lookupReqTag, i);
      end
      exp_q.push_back({i[0], 36'h40 + 36'(i)});
      tick();
    end
    reqEn = 1'b0;
    checks++;
    if (numOutstanding !== 5'd16 || reqRdy !== 1'b0) begin
      errors++;
      $display("FAIL full_rdy: got num=%0d rdy=%b expected num=16 rdy=0", numOutstanding, reqRdy);
    end
    reqEn = 1'b1;
    #1;
    checks++;
    if (svc_lookupEn !== 1'b0) begin
      errors++;
      $display("FAIL full_block: got en=%b expected 0", svc_lookupEn);
    end
    reqEn = 1'b0;
    send_rsp(5'd0, 36'h40, 1'b0);
    rspDeq = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v} || reqRdy !== 1'b0) begin
      errors++;
      $display("FAIL full_deq: got valid=%b pa=%0h rdy=%b expected valid=1 pa=%0h rdy=0",
               rspValid, rspPagePA, reqRdy, exp_v[35:0]);
    end
    tick();
    rspDeq = 1'b0;
    checks++;
    if (reqRdy !== 1'b1 || numOutstanding !== 5'd15) begin
      errors++;
      $display("FAIL full_reopen: got rdy=%b num=%0d expected rdy=1 num=15", reqRdy, numOutstanding);
    end
    reqEn = 1'b1; reqPageVA = 36'h3ff;
    #1;
    checks++;
    if (svc_lookupEn !== 1'b1 || svc_lookupReqTag !== 5'd0) begin
      errors++;
      $display("FAIL full_wrap: got en=%b tag=%0d expected en=1 tag=0", svc_lookupEn, svc_lookupReqTag);
    end
    exp_q.push_back({1'b0, 36'h50});
    tick();
    reqEn = 1'b0;
    checks++;
    if (numOutstanding !== 5'd16) begin
      errors++;
      $display("FAIL full_refill: got num=%0d expected 16", numOutstanding);
    end
    for (int t = 1; t < 16; t++) send_rsp(5'(t), 36'h40 + 36'(t), t[0]);
    send_rsp(5'd0, 36'h50, 1'b0);
    rspDeq = 1'b1;
    for (int i = 0; i < 16; i++) begin
      #1;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h0;
      checks++;
      if ({rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v}) begin
        errors++;
        $display("FAIL full_drain: got valid=%b big=%b pa=%0h expected valid=1 big=%b pa=%0h",
                 rspValid, rspIsBigPage, rspPagePA, exp_v[36], exp_v[35:0]);
      end
      tick();
    end
    rspDeq = 1'b0;
    checks++;
    if (numOutstanding !== 5'd0) begin
      errors++;
      $display("FAIL full_empty: got num=%0d expected 0", numOutstanding);
    end
  endtask

  task automatic test_back_pressure();
    do_reset();
    svc_lookupRdy = 1'b0; reqEn = 1'b1; reqPageVA = 36'h500;
    #1;
    checks++;
    if (svc_lookupEn !== 1'b0 || reqRdy !== 1'b0) begin
      errors++;
      $display("FAIL bp_block: got en=%b rdy=%b expected en=0 rdy=0", svc_lookupEn, reqRdy);
    end
    tick();
    checks++;
    if (numOutstanding !== 5'd0) begin
      errors++;
      $display("FAIL bp_noalloc: got num=%0d expected 0", numOutstanding);
    end
    svc_lookupRdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      reqPageVA = 36'h500 + 36'(i);
      exp_q.push_back({1'b0, 36'h60 + 36'(i)});
      tick();
    end
    reqEn = 1'b0;
    send_rsp(5'd0, 36'h60, 1'b0);
    checks++;
    if (numOutstanding !== 5'd5) begin
      errors++;
      $display("FAIL bp_count: got num=%0d expected 5", numOutstanding);
    end
    reqEn = 1'b1; reqPageVA = 36'h555; rspDeq = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if ({svc_lookupEn, svc_lookupReqTag} !== {1'b1, 5'd5} ||
        {rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v}) begin
      errors++;
      $display("FAIL bp_simul: got en=%b tag=%0d valid=%b pa=%0h expected en=1 tag=5 valid=1 pa=%0h",
               svc_lookupEn, svc_lookupReqTag, rspValid, rspPagePA, exp_v[35:0]);
    end
    tick();
    reqEn = 1'b0; rspDeq = 1'b0;
    checks++;
    if (numOutstanding !== 5'd5 || rspValid !== 1'b0) begin
      errors++;
      $display("FAIL bp_keep5: got num=%0d valid=%b expected num=5 valid=0", numOutstanding, rspValid);
    end
  endtask

  task automatic test_errors();
    do_reset();
    reqEn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      reqPageVA = 36'h700 + 36'(i);
      exp_q.push_back({1'b0, 36'h20 + 36'(i)});
      tick();
    end
    reqEn = 1'b0;
    send_rsp(5'd0, 36'h20, 1'b0);
    checks++;
    if (errTag !== 1'b0) begin
      errors++;
      $display("FAIL err_legal: got err=%b expected 0", errTag);
    end
    send_rsp(5'd7, 36'h77, 1'b0);
    checks++;
    if (errTag !== 1'b1) begin
      errors++;
      $display("FAIL err_unalloc: got err=%b expected 1", errTag);
    end
    send_rsp(5'd1, 36'h21, 1'b0);
    send_rsp(5'd1, 36'h99, 1'b1);
    send_rsp(5'd2, 36'h22, 1'b0);
    checks++;
    if (errTag !== 1'b1) begin
      errors++;
      $display("FAIL err_sticky: got err=%b expected 1", errTag);
    end
    rspDeq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 37'h0;
      checks++;
      if ({rspValid, rspIsBigPage, rspPagePA} !== {1'b1, exp_v}) begin
        errors++;
        $display("FAIL err_drain: got valid=%b big=%b pa=%0h expected valid=1 big=%b pa=%0h",
                 rspValid, rspIsBigPage, rspPagePA, exp_v[36], exp_v[35:0]);
      end
      tick();
    end
    rspDeq = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    reqEn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      reqPageVA = 36'h800 + 36'(i);
      tick();
    end
    reqEn = 1'b0;
    send_rsp(5'd0, 36'h30, 1'b0);
    send_rsp(5'd9, 36'h39, 1'b0);
    checks++;
    if ({rspValid, numOutstanding, errTag} !== {1'b1, 5'd6, 1'b1}) begin
      errors++;
      $display("FAIL mid_pre: got valid=%b num=%0d err=%b expected valid=1 num=6 err=1",
               rspValid, numOutstanding, errTag);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({rspValid, numOutstanding, errTag, reqRdy} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b num=%0d err=%b rdy=%b expected all 0",
               rspValid, numOutstanding, errTag, reqRdy);
    end
    tick();
    reset_n = 1'b1;
    exp_q.delete();
    reqEn = 1'b1; reqPageVA = 36'h900;
    #1;
    checks++;
    if (svc_lookupEn !== 1'b1 || svc_lookupReqTag !== 5'd0) begin
      errors++;
      $display("FAIL mid_first_tag: got en=%b tag=%0d expected en=1 tag=0", svc_lookupEn, svc_lookupReqTag);
    end
    tick();
    reqEn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_back_pressure();
    test_errors();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
